// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM:
// opcode/funct constants, state enumeration, mux-select encodings
// and the one-hot instruction class used between decoder and FSM.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXE    = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  localparam logic [1:0] NPC_PC4    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_REG    = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_LUI = 3'b011;

  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;

  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
    logic nop;
  } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier. Exactly one class bit is set;
// anything unrecognised (and the all-zero word) lands in nop.
module mc_decode
  import mc_pkg::*;
(
  input  logic [31:0] instr_i,
  output iclass_t     cls_o
);

  iclass_t known;

  // map opcode/funct to a class; unmatched encodings fall through to nop
  always_comb begin
    known = '0;
    case (instr_i[31:26])
      OP_RTYPE: begin
        case (instr_i[5:0])
          FN_ADDU: known.addu = 1'b1;
          FN_SUBU: known.subu = 1'b1;
          FN_JR:   known.jr   = 1'b1;
          default: ;
        endcase
      end
      OP_ORI: known.ori = 1'b1;
      OP_LUI: known.lui = 1'b1;
      OP_LW:  known.lw  = 1'b1;
      OP_SW:  known.sw  = 1'b1;
      OP_BEQ: known.beq = 1'b1;
      OP_J:   known.j   = 1'b1;
      OP_JAL: known.jal = 1'b1;
      default: ;
    endcase
    cls_o     = known;
    cls_o.nop = (instr_i == 32'd0) || (known == '0);
    if (instr_i == 32'd0) cls_o = iclass_t'(11'b000_0000_0001);
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS core.
// Optional performance counters (CycleCnt/InstrCnt) when MC_CTRL_PERF_EN is defined.
//
// state     | meaning
// ST_FETCH  | load IR from instruction memory
// ST_DECODE | jumps/nop complete here, others dispatch
// ST_EXE    | ALU operation; beq completes here
// ST_MEM    | data memory access; sw completes here
// ST_WB     | register write-back and PC update
module mc_ctrl
  import mc_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  output logic        PCWr,
  output logic        IRWr,
  output logic [1:0]  NPCOp,
  output logic        Br,
  output logic        RegWr,
  output logic [1:0]  RegDst,
  output logic        ALUSrc,
  output logic [2:0]  ALUOp,
  output logic        ExtOp,
  output logic        MemWr,
  output logic [1:0]  MemToReg,
  output logic        InstrDone
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] CycleCnt,
  output logic [31:0] InstrCnt
`endif
);

  state_e  state_q, state_d;
  iclass_t cls;

  mc_decode u_decode (
    .instr_i (Instr),
    .cls_o   (cls)
  );

  // next state and Moore-style control outputs; everything forced low in reset
  always_comb begin
    state_d  = state_q;
    PCWr     = 1'b0;
    IRWr     = 1'b0;
    NPCOp    = NPC_PC4;
    Br       = 1'b0;
    RegWr    = 1'b0;
    RegDst   = RDST_RT;
    ALUSrc   = 1'b0;
    ALUOp    = ALU_ADD;
    ExtOp    = 1'b0;
    MemWr    = 1'b0;
    MemToReg = M2R_ALU;
    case (state_q)
      ST_FETCH: begin
        IRWr    = 1'b1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (cls.j) begin
          PCWr    = 1'b1;
          NPCOp   = NPC_JUMP;
          state_d = ST_FETCH;
        end else if (cls.jr) begin
          PCWr    = 1'b1;
          NPCOp   = NPC_REG;
          state_d = ST_FETCH;
        end else if (cls.nop) begin
          PCWr    = 1'b1;
          state_d = ST_FETCH;
        end else if (cls.jal) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_EXE;
        end
      end
      ST_EXE: begin
        state_d = ST_WB;
        if (cls.subu) ALUOp = ALU_SUB;
        if (cls.ori) begin
          ALUOp  = ALU_OR;
          ALUSrc = 1'b1;
        end
        if (cls.lui) begin
          ALUOp  = ALU_LUI;
          ALUSrc = 1'b1;
        end
        if (cls.lw || cls.sw) begin
          ALUSrc  = 1'b1;
          ExtOp   = 1'b1;
          state_d = ST_MEM;
        end
        if (cls.beq) begin
          ALUOp   = ALU_SUB;
          PCWr    = 1'b1;
          NPCOp   = NPC_BRANCH;
          Br      = Zero;
          state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        if (cls.sw) begin
          MemWr   = 1'b1;
          PCWr    = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        RegWr   = 1'b1;
        PCWr    = 1'b1;
        state_d = ST_FETCH;
        if (cls.addu || cls.subu) RegDst = RDST_RD;
        if (cls.lw) MemToReg = M2R_MEM;
        if (cls.jal) begin
          RegDst   = RDST_RA;
          MemToReg = M2R_PC4;
          NPCOp    = NPC_JUMP;
        end
      end
      default: state_d = ST_FETCH;
    endcase
    if (Reset) begin
      PCWr     = 1'b0;
      IRWr     = 1'b0;
      NPCOp    = 2'b00;
      Br       = 1'b0;
      RegWr    = 1'b0;
      RegDst   = 2'b00;
      ALUSrc   = 1'b0;
      ALUOp    = 3'b000;
      ExtOp    = 1'b0;
      MemWr    = 1'b0;
      MemToReg = 2'b00;
    end
  end

  assign InstrDone = PCWr;

  // state register; reset aborts any instruction in flight
  always_ff @(posedge CLK) begin
    if (Reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_cnt_q, instr_cnt_q;

  // free-running cycle and retired-instruction counters, wrapping
  always_ff @(posedge CLK) begin
    if (Reset) begin
      cycle_cnt_q <= 32'd0;
      instr_cnt_q <= 32'd0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (InstrDone) instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end

  assign CycleCnt = cycle_cnt_q;
  assign InstrCnt = instr_cnt_q;
`endif

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control FSM for the MIPS core. It sequences the fetch unit, register file, ALU, data memory and write-back muxes so that each instruction takes 2–5 cycles instead of one. It decodes the held instruction register value and issues per-state write enables and mux selects. It also drives the `NPCOp` and `Br` inputs of the fetch unit.

## Interface
Parameters:
- `PC_RESET`, default `32'h00003000`: documentation only; the fetch unit owns the PC reset value. Used by the bench for its expected-PC model.

Ports:
- `CLK`  in  1  single clock. All state changes on the posedge.
- `Reset`  in  1  synchronous, active-high reset.
- `Instr`  in  32  current instruction, held stable by the IR from DECODE onward.
- `Zero`  in  1  ALU equality result, valid in EXE.
- `PCWr`  out  1  PC write enable. Asserted exactly once per instruction, in its last state.
- `IRWr`  out  1  instruction register load enable.
- `NPCOp`  out  2  next-PC select: 00 PC+4, 01 branch, 10 jump target, 11 register (jr).
- `Br`  out  1  branch taken; equals `Zero` in beq EXE, 0 otherwise.
- `RegWr`  out  1  GPR write enable.
- `RegDst`  out  2  write-register select: 00 rt, 01 rd, 10 $31.
- `ALUSrc`  out  1  ALU B operand: 0 rt, 1 extended imm16.
- `ALUOp`  out  3  ALU operation: 000 add, 001 sub, 010 or, 011 lui (imm<<16).
- `ExtOp`  out  1  immediate extension: 0 zero-extend, 1 sign-extend.
- `MemWr`  out  1  data memory write enable.
- `MemToReg`  out  2  write-back data select: 00 ALU, 01 memory, 10 PC+4.
- `InstrDone`  out  1  one-cycle pulse. Identical to `PCWr`.

## Operation
- States: FETCH, DECODE, EXE, MEM, WB. Moore outputs are decoded from the state and from `Instr[31:26]` / `Instr[5:0]`.
- Supported instructions: addu, subu, ori, lui, lw, sw, beq, j, jal, jr, nop (`Instr == 0`). Any other encoding is treated as nop.
- FETCH: `IRWr=1`, all other enables 0. Always moves to DECODE.
- DECODE:
  - j: `PCWr=1`, `NPCOp=10`, then FETCH.
  - jr: `PCWr=1`, `NPCOp=11`, then FETCH.
  - nop or unknown: `PCWr=1`, `NPCOp=00`, then FETCH.
  - jal: go to WB.
  - All other instructions: go to EXE.
- EXE:
  - addu: `ALUOp=000`, `ALUSrc=0`. subu: `ALUOp=001`, `ALUSrc=0`.
  - ori: `ALUOp=010`, `ALUSrc=1`, `ExtOp=0`. lui: `ALUOp=011`, `ALUSrc=1`.
  - lw, sw: `ALUOp=000`, `ALUSrc=1`, `ExtOp=1`, then MEM.
  - beq: `ALUOp=001`, `PCWr=1`, `NPCOp=01`, `Br=Zero`, then FETCH.
  - Other instructions in EXE go to WB.
- MEM:
  - sw: `MemWr=1`, `PCWr=1`, `NPCOp=00`, then FETCH.
  - lw: no enables asserted, then WB.
- WB: `RegWr=1`, `PCWr=1`, then FETCH. Selects per instruction:
  - R-type: `RegDst=01`, `MemToReg=00`.
  - ori, lui: `RegDst=00`, `MemToReg=00`.
  - lw: `RegDst=00`, `MemToReg=01`.
  - jal: `RegDst=10`, `MemToReg=10`, `NPCOp=10`.
- Mux selects not listed for a state are 00/0. `NPCOp` defaults to 00.
- Cycle counts: j, jr, nop = 2; beq, jal = 3; addu, subu, ori, lui, sw = 4; lw = 5.

## Timing
- Reset:
  - Reset asserted at a posedge: state becomes FETCH.
  - While `Reset` is high, all outputs are forced to 0: `PCWr`, `IRWr`, `RegWr`, `MemWr`, `Br`, `InstrDone`, and all selects.
  - The first cycle after `Reset` deasserts is FETCH with `IRWr=1`.
- Reset mid-instruction aborts it: no `PCWr`, `RegWr` or `MemWr` is issued for that instruction, and the PC returns to its reset value.
- `Instr` is sampled combinationally. It must be stable from DECODE until the instruction's last state, which the IR guarantees because `IRWr` is high only in FETCH.
- `PCWr` and `RegWr` / `MemWr` are asserted in the same cycle and take effect at the same posedge. The register/memory write therefore uses the old PC+4 (needed for jal).
- No two instructions overlap. `InstrDone` is followed by FETCH on the next cycle.

## Configuration
- `MC_CTRL_PERF_EN` defined:
  - Adds output ports `CycleCnt` (32 bits) and `InstrCnt` (32 bits). Both reset to 0 and wrap modulo 2^32.
  - `CycleCnt` increments every non-reset cycle.
  - `InstrCnt` increments on each `InstrDone`.
- Undefined: the ports and counters are absent, and the rest of the behaviour is identical.

## Structure
- Package `mc_pkg` holds:
  - opcode and funct constants;
  - the state enumeration;
  - `NPCOp`, `ALUOp`, `RegDst` and `MemToReg` encodings.
- Sub-module `mc_decode`: combinational; maps `Instr` to a one-hot instruction class (rtype_addu, rtype_subu, ori, lui, lw, sw, beq, j, jal, jr, nop). `mc_ctrl` instantiates it once.

## Test plan
- Reset held 3 cycles, then released. Expect FETCH with `IRWr=1` on the first free cycle, and `PCWr=0` throughout reset.
- `addu` (`Instr = 32'h00851821`). Expect 4 cycles; `PCWr`, `RegWr`, `RegDst=01` and `MemToReg=00` all in cycle 4 only.
- `lw` followed by `sw`. Expect lw to take 5 cycles with `MemToReg=01` in WB, and sw to take 4 cycles with `MemWr=1` in MEM. `InstrDone` count = 2.
- `beq` driven with `Zero=1`, then with `Zero=0`. Expect 3 cycles each and `NPCOp=01` in EXE, with `Br=1` and `Br=0` respectively.
- `jal` (`Instr = 32'h0C000C00`). Expect 3 cycles; in WB, `RegDst=10`, `MemToReg=10`, `NPCOp=10` and `RegWr=1`. Then `jr` takes 2 cycles with `NPCOp=11`.
- Reset asserted during lw MEM. Expect no `RegWr`, and FETCH after release. With `MC_CTRL_PERF_EN` defined, `InstrCnt` reads 0 after the reset.
